click_decoder: RTL and testbench
================================

CLICK_DECODER -- requirements
Module: click_decoder

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50_000_000: system clock frequency in Hz.
REQ-002 The block SHALL have parameter WINDOW_MS, default 300: double-click window in milliseconds.
REQ-003 The block SHALL have parameter COUNT_WIDTH, default 8: width of click_count.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_a_p, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port press_in, input, 1 bit: debounced one-shot button pulse of any width, asynchronous to clk.
REQ-007 The block SHALL have port single_click, output, 1 bit: one-cycle pulse marking a classified single click.
REQ-008 The block SHALL have port double_click, output, 1 bit: one-cycle pulse marking a classified double click.
REQ-009 The block SHALL have port click_count, output, COUNT_WIDTH bits: running count of detected press edges.
REQ-010 The block SHALL have port busy, output, 1 bit: high while the state is not IDLE.

Function
REQ-011 The block SHALL define WINDOW_CYCLES = (CLK_FREQ/1000)*WINDOW_MS, integer arithmetic; WINDOW_CYCLES < 2 is an illegal configuration.
REQ-012 The block SHALL pass press_in through a two-flop synchronizer, then a third flop; press_edge = sync2 & ~sync3.
REQ-013 The block SHALL generate exactly one press_edge per press_in low-to-high transition, regardless of pulse width.
REQ-014 press_edge SHALL be high two to three clk edges after press_in rises; a press_in high for fewer than 2 cycles MAY be missed.
REQ-015 The block SHALL use three states: IDLE, WAIT_SECOND, COOLDOWN.
REQ-016 In IDLE, on press_edge, the block SHALL load the timer with WINDOW_CYCLES-1 and enter WAIT_SECOND.
REQ-017 In WAIT_SECOND without press_edge and with timer != 0, the block SHALL decrement the timer by 1 per cycle.
REQ-018 In WAIT_SECOND, on press_edge, the block SHALL assert double_click on the next cycle, reload the timer with WINDOW_CYCLES-1 and enter COOLDOWN.
REQ-019 In WAIT_SECOND, with timer == 0 and no press_edge, the block SHALL assert single_click on the next cycle and enter IDLE.
REQ-020 When press_edge and timer == 0 coincide in WAIT_SECOND, the block SHALL treat the press as double (press_edge wins).
REQ-021 In COOLDOWN, the block SHALL ignore press_edge for classification, decrement the timer, and enter IDLE at timer == 0 with no pulse.
REQ-022 single_click and double_click SHALL be registered, one cycle wide, and never asserted together.
REQ-023 click_count SHALL increment by 1 on every press_edge in any state, including COOLDOWN.
REQ-024 click_count SHALL wrap from 2^COUNT_WIDTH-1 to 0.
REQ-025 busy SHALL be a registered decode: 1 in WAIT_SECOND or COOLDOWN, 0 in IDLE.

Reset
REQ-026 While rst_a_p is high, the block SHALL immediately force: state = IDLE; timer, all synchronizer flops, single_click, double_click and busy = 0; click_count = 0.
REQ-027 Reset asserted mid-window SHALL abort classification with no pulse emitted after reset release.
REQ-028 After reset release, a press_in already high SHALL be counted as one edge on the first rising edge seen by the synchronizer.

Verification (CLK_FREQ=1000, WINDOW_MS=10 -> WINDOW_CYCLES=10, COUNT_WIDTH=4)
REQ-029 Single press: press_in high 3 cycles, no further presses -> exactly one single_click pulse, ~12-13 cycles after the edge; click_count=1; busy low afterwards.
REQ-030 Double press: two presses whose edges are 5 cycles apart -> one double_click one cycle after the second press_edge, no single_click; busy high through COOLDOWN; click_count=2.
REQ-031 Boundary cases:
- second press_edge on the timer==0 cycle -> double_click;
- second press_edge one cycle later -> single_click, then a new WAIT_SECOND.
REQ-032 Triple press: three edges within 6 cycles -> one double_click only; click_count=3; state returns to IDLE 10 cycles after the double.
REQ-033 Wrap: 17 isolated presses -> click_count=1.
REQ-034 Mid-window reset: rst_a_p pulse 4 cycles after the first press -> all outputs 0, no click pulse for 20 cycles after release.

Source files
------------

// File: rtl/click_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : click_decoder
//  Purpose  : Classifies button presses into single and double clicks.
//             press_in is synchronised, edge-detected, and each rising edge
//             either opens a double-click window, closes it as a double
//             click, or is ignored for classification during the cooldown
//             that follows a double click. Every edge is counted.
//  Ports    : clk          - system clock, rising-edge active
//             rst_a_p      - asynchronous active-high reset
//             press_in     - debounced button pulse, asynchronous to clk
//             single_click - one-cycle pulse, single click classified
//             double_click - one-cycle pulse, double click classified
//             click_count  - running count of press edges (wraps)
//             busy         - high while not IDLE
//  Revision : 1.0 - initial release
// ============================================================================
module click_decoder #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int WINDOW_MS   = 300,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_a_p,
  input  logic                   press_in,
  output logic                   single_click,
  output logic                   double_click,
  output logic [COUNT_WIDTH-1:0] click_count,
  output logic                   busy
);

  // WINDOW_CYCLES below 2 is not a legal configuration.
  localparam int WINDOW_CYCLES = (CLK_FREQ / 1000) * WINDOW_MS;
  localparam int TIMER_W       = $clog2(WINDOW_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(WINDOW_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_WAIT_SECOND = 2'd1,
    ST_COOLDOWN    = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [TIMER_W-1:0]     timer_q, timer_d;
  logic                   sync1_q, sync1_d;
  logic                   sync2_q, sync2_d;
  logic                   sync3_q, sync3_d;
  logic                   single_q, single_d;
  logic                   double_q, double_d;
  logic                   busy_q, busy_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   press_edge;

  // sync1/sync2 form the synchroniser; sync3 only delays for edge detection.
  assign press_edge = sync2_q & ~sync3_q;

  always_comb begin
    sync1_d  = press_in;
    sync2_d  = sync1_q;
    sync3_d  = sync2_q;
    state_d  = state_q;
    timer_d  = timer_q;
    single_d = 1'b0;
    double_d = 1'b0;
    count_d  = count_q;

    // Counting is independent of classification, so cooldown edges count too.
    if (press_edge) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (press_edge) begin
          timer_d = TIMER_LOAD;
          state_d = ST_WAIT_SECOND;
        end
      end
      ST_WAIT_SECOND: begin
        // A press on the final window cycle still counts as a double.
        if (press_edge) begin
          double_d = 1'b1;
          timer_d  = TIMER_LOAD;
          state_d  = ST_COOLDOWN;
        end else if (timer_q == '0) begin
          single_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      ST_COOLDOWN: begin
        if (timer_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase

    // Decoded from the next state so busy is registered in step with state_q.
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst_a_p) begin
    if (rst_a_p) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sync3_q  <= 1'b0;
      single_q <= 1'b0;
      double_q <= 1'b0;
      busy_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      sync3_q  <= sync3_d;
      single_q <= single_d;
      double_q <= double_d;
      busy_q   <= busy_d;
      count_q  <= count_d;
    end
  end

  assign single_click = single_q;
  assign double_click = double_q;
  assign click_count  = count_q;
  assign busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_click_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_click_decoder
//  Purpose  : Self-checking bench for click_decoder with a 10-cycle window
//             (CLK_FREQ=1000, WINDOW_MS=10) and a 4-bit click counter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_click_decoder;

  localparam int WIN = 10;  // (1000/1000)*10

  logic       clk = 1'b0;
  logic       rst_a_p = 1'b1;
  logic       press_in = 1'b0;
  logic       single_click;
  logic       double_click;
  logic [3:0] click_count;
  logic       busy;

  int errors = 0;
  int checks = 0;

  click_decoder #(
    .CLK_FREQ   (1000),
    .WINDOW_MS  (10),
    .COUNT_WIDTH(4)
  ) dut (
    .clk         (clk),
    .rst_a_p     (rst_a_p),
    .press_in    (press_in),
    .single_click(single_click),
    .double_click(double_click),
    .click_count (click_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model. Works from absolute cycle numbers: a first press opens a
  // window lasting WIN cycles after its edge cycle; a second edge inside it is
  // a double click and starts a WIN-cycle cooldown; an empty window ends in a
  // single click. Edge of cycle j is press sampled high at j-1 and low at j-2.
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [1:0]  mode;   // 0 idle, 1 window open, 2 cooldown
    logic [31:0] t_end;  // last cycle of the current window/cooldown
    logic [3:0]  cnt;
    logic        sgl;
    logic        dbl;
  } mstate_t;

  function automatic mstate_t step(input mstate_t s, input logic ev, input logic [31:0] j);
    mstate_t n;
    n     = s;
    n.sgl = 1'b0;
    n.dbl = 1'b0;
    if (s.mode == 2'd0) begin
      if (ev) begin
        n.mode  = 2'd1;
        n.t_end = j + WIN;
      end
    end else if (s.mode == 2'd1) begin
      if (ev) begin
        n.dbl   = 1'b1;
        n.mode  = 2'd2;
        n.t_end = j + WIN;
      end else if (j == s.t_end) begin
        n.sgl  = 1'b1;
        n.mode = 2'd0;
      end
    end else begin
      if (j == s.t_end) n.mode = 2'd0;
    end
    if (ev) n.cnt = s.cnt + 4'd1;
    return n;
  endfunction

  int      cyc = 0;
  mstate_t m;
  logic    h1, h2, h3;  // press_in samples from 1, 2 and 3 clocks ago

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst_a_p) begin
    if (rst_a_p) begin
      m  <= '0;
      h1 <= 1'b0;
      h2 <= 1'b0;
      h3 <= 1'b0;
    end else begin
      m  <= step(m, h2 & ~h3, cyc);
      h1 <= press_in;
      h2 <= h1;
      h3 <= h2;
    end
  end

  // Per-cycle comparison against the model, plus pulse statistics used by
  // the directed literal checks.
  int n_single = 0, n_double = 0;
  int last_single = 0, last_double = 0, busy_fall = 0;
  logic busy_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst_a_p) begin
      chk("single_click", 32'(single_click), 32'(m.sgl));
      chk("double_click", 32'(double_click), 32'(m.dbl));
      chk("busy", 32'(busy), 32'(m.mode != 2'd0));
      chk("click_count", 32'(click_count), 32'(m.cnt));
      if (single_click) begin
        n_single    <= n_single + 1;
        last_single <= cyc;
      end
      if (double_click) begin
        n_double    <= n_double + 1;
        last_double <= cyc;
      end
      if (busy_prev && !busy) busy_fall <= cyc;
      busy_prev <= busy;
    end else begin
      busy_prev <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers. All input changes happen on the falling edge.
  // --------------------------------------------------------------------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raises press_in for w samples; rise is the cycle whose edge first samples it.
  task automatic pulse(input int w, output int rise);
    @(negedge clk);
    press_in = 1'b1;
    rise     = cyc + 1;
    repeat (w) @(negedge clk);
    press_in = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_a_p  = 1'b1;
    press_in = 1'b0;
    idle(2);
    rst_a_p = 1'b0;
  endtask

  int r1, r2, r3, s0, d0;

  initial begin
    // Reset state
    idle(2);
    #1;
    chk("reset_single", 32'(single_click), 32'd0);
    chk("reset_double", 32'(double_click), 32'd0);
    chk("reset_count", 32'(click_count), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst_a_p = 1'b0;

    // Single press
    do_reset();
    s0 = n_single; d0 = n_double;
    pulse(3, r1);
    idle(25); #2;
    chk("single_n", 32'(n_single - s0), 32'd1);
    chk("single_nd", 32'(n_double - d0), 32'd0);
    chk("single_lat", 32'(last_single - r1), 32'd12);
    chk("single_cnt", 32'(click_count), 32'd1);
    chk("single_busy", 32'(busy), 32'd0);

    // Double press, edges 5 apart
    do_reset();
    s0 = n_single; d0 = n_double;
    pulse(2, r1); idle(2); pulse(2, r2);
    chk("dbl_gap", 32'(r2 - r1), 32'd5);
    idle(25); #2;
    chk("dbl_n", 32'(n_double - d0), 32'd1);
    chk("dbl_ns", 32'(n_single - s0), 32'd0);
    chk("dbl_lat", 32'(last_double - r2), 32'd2);
    chk("dbl_cool", 32'(busy_fall - last_double), 32'd10);
    chk("dbl_cnt", 32'(click_count), 32'd2);

    // Second edge on the timer==0 cycle
    do_reset();
    s0 = n_single; d0 = n_double;
    pulse(2, r1); idle(7); pulse(2, r2);
    idle(25); #2;
    chk("edge0_gap", 32'(r2 - r1), 32'd10);
    chk("edge0_n", 32'(n_double - d0), 32'd1);
    chk("edge0_ns", 32'(n_single - s0), 32'd0);
    chk("edge0_lat", 32'(last_double - r2), 32'd2);

    // Second edge one cycle too late: single, then a fresh window
    do_reset();
    s0 = n_single; d0 = n_double;
    pulse(2, r1); idle(8); pulse(2, r2);
    idle(25); #2;
    chk("late_gap", 32'(r2 - r1), 32'd11);
    chk("late_ns", 32'(n_single - s0), 32'd2);
    chk("late_nd", 32'(n_double - d0), 32'd0);
    chk("late_lat", 32'(last_single - r2), 32'd12);
    chk("late_cnt", 32'(click_count), 32'd2);

    // Triple press within 6 cycles
    do_reset();
    s0 = n_single; d0 = n_double;
    pulse(2, r1); pulse(2, r2); pulse(2, r3);
    idle(25); #2;
    chk("tri_span", 32'(r3 - r1), 32'd6);
    chk("tri_nd", 32'(n_double - d0), 32'd1);
    chk("tri_ns", 32'(n_single - s0), 32'd0);
    chk("tri_cnt", 32'(click_count), 32'd3);
    chk("tri_idle", 32'(busy_fall - last_double), 32'd10);

    // Counter wrap: 17 isolated presses
    do_reset();
    s0 = n_single;
    for (int i = 0; i < 17; i++) begin
      pulse(2, r1);
      idle(14);
    end
    #2;
    chk("wrap_cnt", 32'(click_count), 32'd1);
    chk("wrap_ns", 32'(n_single - s0), 32'd17);

    // Mid-window reset
    do_reset();
    pulse(2, r1); idle(2);
    #1;
    chk("mid_busy_pre", 32'(busy), 32'd1);
    rst_a_p = 1'b1;
    #1;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_cnt", 32'(click_count), 32'd0);
    chk("mid_pulses", 32'(single_click | double_click), 32'd0);
    idle(2);
    rst_a_p = 1'b0;
    s0 = n_single; d0 = n_double;
    idle(20); #2;
    chk("mid_ns", 32'(n_single - s0), 32'd0);
    chk("mid_nd", 32'(n_double - d0), 32'd0);
    chk("mid_busy_post", 32'(busy), 32'd0);

    // press_in already high at reset release counts once
    @(negedge clk);
    rst_a_p  = 1'b1;
    press_in = 1'b1;
    idle(2);
    rst_a_p = 1'b0;
    s0 = n_single;
    idle(5); #2;
    chk("held_cnt", 32'(click_count), 32'd1);
    press_in = 1'b0;
    idle(20); #2;
    chk("held_ns", 32'(n_single - s0), 32'd1);
    chk("held_cnt_end", 32'(click_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
